mul_seq_64: RTL and testbench
=============================

# mul_seq_64

Sequential radix-2 shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU group in the sequential processor's execute stage. It sits directly upstream of the 64-bit ripple adder: each cycle it feeds the adder the running partial-product high half and the multiplicand, then consumes the sum and carry. The control FSM issues a `start`, waits for a one-cycle `done` pulse, and reads `result`.

## Interface
- `XLEN`, 64: operand and result width. Only 64 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only in IDLE.
- `flush`  in  1  synchronous abort. Returns to IDLE with no `done`.
- `op`  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU. Captured with `start`.
- `a`  in  XLEN  rs1 operand. Captured with `start`.
- `b`  in  XLEN  rs2 operand. Captured with `start`.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  XLEN  product slice. Held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE to CALC on `start`:
  - Latch `op`.
  - Latch magnitudes of `a` and `b`. `a` is signed for MULH and MULHSU; `b` is signed for MULH only. All other operands are unsigned.
  - Latch `neg = sign(a) ^ sign(b)`, using only the signed operands.
  - Clear the 128-bit accumulator {hi, lo}. Load the multiplier into `lo`. Clear the iteration count.
- CALC, one iteration per cycle:
  - If `lo[0]` is set, form `sum = {1'b0, hi} + {1'b0, mcand}`; otherwise `sum = {1'b0, hi}`. `sum` is 65 bits.
  - Update `{hi, lo} <= {sum, lo[63:1]}`, i.e. shift right by one with the carry entering `hi[63]`.
  - On the 64th iteration, go to FIX.
- FIX:
  - Compute `p = neg ? -{hi, lo} : {hi, lo}` with a 128-bit two's-complement negation.
  - `result <= (op == MUL) ? p[63:0] : p[127:64]`.
  - Pulse `done`, return to IDLE.
- A magnitude of 0x8000_0000_0000_0000 (the most negative value) is treated as unsigned 2^63. There is no overflow case; all products fit in 128 bits.
- `start` while `busy` is ignored, with no queueing.
- `flush` wins over every other event in every state. It returns to IDLE, `done` stays 0, and `result` keeps its previous value.
- `start` and `flush` in the same IDLE cycle: `flush` wins and the request is dropped.
- Reset values: state IDLE; `busy`, `done` and `result` all 0; accumulator, count and `neg` all 0. Reset mid-operation aborts immediately with no `done`.

## Timing
- `start` is sampled at edge E0.
- Without early exit, iterations happen at E1..E64 and FIX at E65. `done` is high for the single cycle after E65, and `busy` falls at the same edge. Latency is 65 cycles.
- A new `start` may be presented in the cycle `done` is high (state is already IDLE), giving back-to-back operation.
- `result` is registered and stable from the `done` cycle until the next accepted `start` plus 65 edges. It does not change at `start`.

## Configuration
- Macro: `MUL_SEQ_EARLY_EXIT_EN`.
- Defined: after each iteration, if the shifted multiplier bits remaining in `lo` are all zero, the FSM goes to FIX and the accumulator is realigned by the number of skipped shifts.
  - Iterations k = max(1, msb_index(|b|) + 1). `done` follows edge E(k+1).
  - Example: b = 0 gives `done` after E2.
- Undefined: a fixed 64 iterations; latency is always 65.
- Results are identical in both builds.

## Structure
- Shared package `riscv_pkg`:
  - `mul_op_e` enum (MUL, MULH, MULHSU, MULHU with the encodings above).
  - `MUL_ITERS = 64` constant.
  - FSM state typedef.
- Sub-module `mul_acc_step`: combinational single-iteration datapath (conditional 65-bit add plus shift). Its adder is a 64-bit ripple adder; the true carry is bit 64 of the zero-extended sum, not a gated carry output.
- FSM, counter and FIX negation live in the top level.

## Test plan
- MUL, a=3, b=5 -> `done` exactly 65 cycles after `start` (fixed build), `result` = 15, `busy` low the same cycle.
- MULH, a=b=0xFFFF_FFFF_FFFF_FFFF -> `result` = 0. A following MUL with the same operands -> 1.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF -> `result` = 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU, a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF -> `result` = 0xFFFF_FFFF_FFFF_FFFF.
- MULH, a=b=0x8000_0000_0000_0000 -> `result` = 0x4000_0000_0000_0000.
- Second `start` at cycle 10 is ignored. Then:
  - `flush` at cycle 30 returns to IDLE with no `done` and `result` unchanged.
  - `rst_n` low mid-CALC clears all outputs to 0.
  - Early-exit build, b=0 -> `done` after E2 with `result` = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64M multiplier definitions: operation encodings, iteration count,
// FSM state type and an operand magnitude helper.
package riscv_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   localparam int MUL_ITERS = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } mul_state_e;

   // Two's-complement magnitude; the most negative value maps to unsigned 2^63.
   function automatic logic [63:0] mag64(input logic [63:0] v, input logic is_neg);
      return is_neg ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/mul_acc_step.sv
// One radix-2 shift-add iteration: conditional 65-bit add of the multiplicand
// into the high half, then a one-bit right shift of the whole accumulator with
// the adder carry entering the top of the high half.
module mul_acc_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_mcand,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN-1:0] w_addend;
   logic [XLEN:0]   w_sum;

   assign w_addend = i_lo[0] ? i_mcand : '0;
   // Zero-extended add: bit XLEN of the sum is the true carry out.
   assign w_sum    = {1'b0, i_hi} + {1'b0, w_addend};
   assign o_hi     = w_sum[XLEN:1];
   assign o_lo     = {w_sum[0], i_lo[XLEN-1:1]};

endmodule

// File: rtl/mul_seq_64.sv
// Sequential radix-2 multiplier for MUL/MULH/MULHSU/MULHU.
// Optional feature macro: MUL_SEQ_EARLY_EXIT_EN -- when defined, the FSM leaves
// CALC as soon as the remaining multiplier bits are all zero and realigns the
// accumulator; results are identical either way.
module mul_seq_64
   import riscv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   mul_state_e        r_state;
   mul_op_e           r_op;
   logic              r_neg;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_mcand;
   logic [6:0]        r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_a_sgn;
   logic              w_b_sgn;
   logic [XLEN-1:0]   w_hi_next;
   logic [XLEN-1:0]   w_lo_next;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_p;

   // Only MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
   assign w_a_sgn = ((op == MULH) || (op == MULHSU)) && a[XLEN-1];
   assign w_b_sgn = (op == MULH) && b[XLEN-1];

   mul_acc_step #(.XLEN(XLEN)) u_step (
      .i_hi    (r_hi),
      .i_lo    (r_lo),
      .i_mcand (r_mcand),
      .o_hi    (w_hi_next),
      .o_lo    (w_lo_next)
   );

   assign w_prod = {r_hi, r_lo};
   assign w_p    = r_neg ? (~w_prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : w_prod;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   logic [6:0]        w_n;
   logic [6:0]        w_skip;
   logic              w_rest_zero;
   logic [2*XLEN-1:0] w_realign;

   // After w_n iterations the low XLEN-w_n bits of lo still hold multiplier bits.
   assign w_n         = r_cnt + 7'd1;
   assign w_rest_zero = ((w_lo_next << w_n) == '0);
   assign w_skip      = 7'(MUL_ITERS) - w_n;
   assign w_realign   = {w_hi_next, w_lo_next} >> w_skip;
`endif

   // Control FSM, iteration counter and accumulator; flush beats everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= MUL;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mcand  <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_op    <= mul_op_e'(op);
                     r_neg   <= w_a_sgn ^ w_b_sgn;
                     r_mcand <= mag64(a, w_a_sgn);
                     r_lo    <= mag64(b, w_b_sgn);
                     r_hi    <= '0;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_CALC;
                  end
               end
               ST_CALC: begin
                  r_cnt <= r_cnt + 7'd1;
`ifdef MUL_SEQ_EARLY_EXIT_EN
                  if (w_rest_zero) begin
                     {r_hi, r_lo} <= w_realign;
                     r_state      <= ST_FIX;
                  end else begin
                     r_hi <= w_hi_next;
                     r_lo <= w_lo_next;
                  end
`else
                  r_hi <= w_hi_next;
                  r_lo <= w_lo_next;
                  if (r_cnt == 7'(MUL_ITERS - 1)) begin
                     r_state <= ST_FIX;
                  end
`endif
               end
               ST_FIX: begin
                  r_result <= (r_op == MUL) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN];
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_mul_seq_64.sv
// Scoreboard bench for mul_seq_64: stimulus pushes expected result and done
// cycle; a monitor pops and compares on every done pulse.
module tb_mul_seq_64;
   import riscv_pkg::*;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q[$];
   exp_t e;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   mul_seq_64 #(.XLEN(64)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .flush  (flush),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Cycle count (as seen at the monitor) from issue to the done pulse.
   function automatic int exp_lat(input logic [1:0] o, input logic [63:0] bb);
`ifdef MUL_SEQ_EARLY_EXIT_EN
      logic [63:0] m;
      int k;
      m = (o == 2'b01 && bb[63]) ? (~bb + 64'd1) : bb;
      k = 1;
      for (int i = 0; i < 64; i++) if (m[i]) k = i + 1;
      return k + 2;
`else
      return 66;
`endif
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("busy_at_done", {63'd0, busy}, 64'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [63:0] aa, input logic [63:0] bb,
                        input logic [63:0] res);
      exp_t x;
      op = o; a = aa; b = bb; start = 1'b1;
      x.res = res;
      x.cyc = cyc + exp_lat(o, bb);
      q.push_back(x);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) begin
         chk("idle_timeout", 64'd1, 64'd0);
         q.delete();
      end
   endtask

   task automatic run(input logic [1:0] o, input logic [63:0] aa, input logic [63:0] bb,
                      input logic [63:0] res);
      issue(o, aa, bb, res);
      wait_idle();
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n;
      wait_cycles(3);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_result", result, 64'd0);
      rst_n = 1'b1;
      wait_cycles(2);

      run(2'b00, 64'd3, 64'd5, 64'd15);
      run(2'b01, ONES, ONES, 64'd0);
      run(2'b00, ONES, ONES, 64'd1);
      run(2'b11, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
      run(2'b10, ONES, ONES, ONES);
      run(2'b01, MINV, MINV, 64'h4000_0000_0000_0000);
      run(2'b01, MINV, ONES, 64'd0);
      run(2'b01, MINV, 64'd1, ONES);
      run(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB);
      run(2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, ONES);
      run(2'b11, MINV, 64'd4, 64'd2);
      run(2'b00, 64'd5, 64'd0, 64'd0);

      // Back-to-back: second start presented in the done cycle.
      issue(2'b00, 64'd6, 64'd7, 64'd42);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      issue(2'b11, 64'd3, MINV, 64'd1);
      wait_idle();

      // Start while busy is ignored.
      issue(2'b00, 64'd3, 64'd5, 64'd15);
      wait_cycles(9);
      op = 2'b11; a = ONES; b = ONES; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_during_ignored_start", {63'd0, busy}, 64'd1);
      wait_idle();

      // Flush mid-CALC: no done, result keeps 15.
      issue(2'b00, ONES, ONES, 64'd1);
      wait_cycles(29);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      void'(q.pop_back());
      chk("flush_busy", {63'd0, busy}, 64'd0);
      chk("flush_done", {63'd0, done}, 64'd0);
      wait_cycles(80);
      chk("flush_result_kept", result, 64'd15);

      // Start and flush together in IDLE: request dropped.
      op = 2'b00; a = 64'd2; b = 64'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("start_flush_idle_busy", {63'd0, busy}, 64'd0);
      wait_cycles(80);
      chk("start_flush_result_kept", result, 64'd15);

      // Asynchronous reset mid-CALC.
      issue(2'b11, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_cycles(20);
      rst_n = 1'b0;
      #2;
      q.delete();
      chk("midreset_busy", {63'd0, busy}, 64'd0);
      chk("midreset_done", {63'd0, done}, 64'd0);
      chk("midreset_result", result, 64'd0);
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(2);

      run(2'b00, 64'd3, 64'd5, 64'd15);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
